// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared fetch-stage definitions: NOP encoding, reset vector,
//               fetch-state encoding and an alignment helper.
// Revision    : 1.0
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] C_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } if_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage with PC, IF/ID register, redirect,
//               stall and misaligned-target halt handling.
// Revision    : 1.0
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr_o,
    output logic        inst_ce_o,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_misalign;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_pc_inc;
    logic        w_target_ok;

    assign w_pc_inc    = r_pc + C_PC_STEP;
    assign w_target_ok = is_word_aligned(target_i);

    // Memory is only enabled while actually fetching; reset gates it at once.
    assign inst_ce_o   = (r_state == ST_RUN) && !rst;
    assign inst_addr_o = r_pc;
    assign id_pc_o     = r_id_pc;
    assign id_inst_o   = r_id_inst;
    assign id_valid_o  = r_id_valid;
    assign misalign_o  = r_misalign;
    assign fetch_cnt_o = r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_id_pc     <= 32'd0;
            r_id_inst   <= NOP_INST;
            r_id_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    r_pc    <= RESET_PC;
                end
                ST_RUN: begin
                    if (flush_i) begin
                        // Redirect squashes the wrong-path word fetched this cycle.
                        r_id_inst  <= NOP_INST;
                        r_id_valid <= 1'b0;
                        if (w_target_ok) begin
                            r_pc <= target_i;
                        end else begin
                            r_misalign <= 1'b1;
                            r_state    <= ST_HALT;
                        end
                    end else if (!stall_i) begin
                        r_id_pc     <= r_pc;
                        r_id_inst   <= inst_i;
                        r_id_valid  <= 1'b1;
                        r_pc        <= w_pc_inc;
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                    end
                end
                ST_HALT: begin
                    r_id_inst  <= NOP_INST;
                    r_id_valid <= 1'b0;
                end
                default: begin
                    r_state    <= ST_HALT;
                    r_id_inst  <= NOP_INST;
                    r_id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: directed scenarios plus
//               randomized traffic against a behavioural fetch model.
// Revision    : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr_o;
    logic        inst_ce_o;
    logic [31:0] inst_i;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] target_i = 32'd0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_key = 32'd0;

    // Instruction memory: word at address N holds N ^ mem_key.
    assign inst_i = inst_addr_o ^ mem_key;

    if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr_o(inst_addr_o),
        .inst_ce_o  (inst_ce_o),
        .inst_i     (inst_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .target_i   (target_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o),
        .misalign_o (misalign_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: m_booting / m_halted describe where the stage is.
    bit          m_booting = 1'b1;
    bit          m_halted  = 1'b0;
    logic [31:0] m_pc      = RST_PC;
    logic [31:0] m_id_pc   = 32'd0;
    logic [31:0] m_id_inst = NOP;
    bit          m_valid   = 1'b0;
    bit          m_mis     = 1'b0;
    logic [31:0] m_cnt     = 32'd0;

    task automatic model_edge();
        if (rst) begin
            m_booting = 1; m_halted = 0; m_pc = RST_PC; m_id_pc = 0;
            m_id_inst = NOP; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (!m_halted) begin
            if (flush_i) begin
                m_id_inst = NOP; m_valid = 0;
                if (target_i % 4 != 0) begin m_mis = 1; m_halted = 1; end
                else m_pc = target_i;
            end else if (!stall_i) begin
                m_id_pc = m_pc; m_id_inst = m_pc ^ mem_key; m_valid = 1;
                m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; stall_i = 0; flush_i = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; stall_i = 1; flush_i = 1; target_i = 32'h0000_0102;
        tick();
        tick();
        checks++; if (inst_ce_o !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", inst_ce_o); end
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
        checks++; if (id_inst_o !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", id_inst_o, NOP); end
        checks++; if (id_pc_o !== 32'd0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc_o); end
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", misalign_o); end
        checks++; if (fetch_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt_o); end
        checks++; if (inst_addr_o !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", inst_addr_o, RST_PC); end
        stall_i = 0; flush_i = 0;
    endtask

    task automatic test_sequential();
        do_reset();
        tick();  // edge 1: BOOT -> RUN
        checks++; if (inst_ce_o !== 1'b1 || id_valid_o !== 1'b0) begin failures++; $display("FAIL boot_exit ce=%b valid=%b exp ce=1 valid=0", inst_ce_o, id_valid_o); end
        for (int k = 2; k <= 5; k++) begin
            tick();
            checks++;
            if (id_pc_o !== 32'(4 * (k - 2)) || id_inst_o !== 32'(4 * (k - 2)) || id_valid_o !== 1'b1) begin
                failures++; $display("FAIL seq_edge%0d pc=%h inst=%h valid=%b exp=%h", k, id_pc_o, id_inst_o, id_valid_o, 32'(4 * (k - 2)));
            end
        end
        checks++; if (fetch_cnt_o !== 32'd4) begin failures++; $display("FAIL seq_cnt got=%0d exp=4", fetch_cnt_o); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 4; k++) tick();  // id_pc = 8
        stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (id_pc_o !== 32'd8 || inst_addr_o !== 32'd12 || fetch_cnt_o !== 32'd3) begin
                failures++; $display("FAIL stall_hold pc=%h addr=%h cnt=%0d exp 8/c/3", id_pc_o, inst_addr_o, fetch_cnt_o);
            end
        end
        stall_i = 0;
        tick();
        checks++; if (id_pc_o !== 32'd12 || fetch_cnt_o !== 32'd4) begin failures++; $display("FAIL stall_resume pc=%h cnt=%0d exp c/4", id_pc_o, fetch_cnt_o); end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        cnt_before = fetch_cnt_o;
        flush_i = 1; stall_i = 1; target_i = 32'h100;
        tick();
        flush_i = 0; stall_i = 0;
        checks++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h13) begin failures++; $display("FAIL flush_slot valid=%b inst=%h exp 0/13", id_valid_o, id_inst_o); end
        checks++; if (inst_addr_o !== 32'h100) begin failures++; $display("FAIL flush_addr got=%h exp=100", inst_addr_o); end
        checks++; if (fetch_cnt_o !== cnt_before) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", fetch_cnt_o, cnt_before); end
        tick();
        checks++; if (id_pc_o !== 32'h100 || id_valid_o !== 1'b1) begin failures++; $display("FAIL flush_next pc=%h valid=%b exp 100/1", id_pc_o, id_valid_o); end
    endtask

    task automatic test_wrap();
        flush_i = 1; target_i = 32'hFFFF_FFFC;
        tick();
        flush_i = 0;
        tick();
        checks++; if (inst_addr_o !== 32'd0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", inst_addr_o); end
        checks++; if (id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_id pc=%h inst=%h exp fffffffc", id_pc_o, id_inst_o); end
    endtask

    task automatic test_misalign();
        logic [31:0] pc_before;
        pc_before = inst_addr_o;
        flush_i = 1; target_i = 32'h102;
        tick();
        checks++; if (inst_addr_o !== pc_before) begin failures++; $display("FAIL mis_pc got=%h exp=%h", inst_addr_o, pc_before); end
        for (int k = 0; k < 6; k++) begin
            flush_i = 1'($urandom_range(0, 1)); stall_i = 1'($urandom_range(0, 1));
            target_i = $urandom & 32'hFFFF_FFFC;
            tick();
            checks++;
            if (misalign_o !== 1'b1 || inst_ce_o !== 1'b0 || id_valid_o !== 1'b0 || id_inst_o !== NOP) begin
                failures++; $display("FAIL mis_halt mis=%b ce=%b valid=%b inst=%h exp 1/0/0/13", misalign_o, inst_ce_o, id_valid_o, id_inst_o);
            end
        end
        flush_i = 0; stall_i = 0;
        do_reset();
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", misalign_o); end
    endtask

    task automatic test_mid_reset();
        tick();
        flush_i = 1; target_i = 32'h40;
        tick();
        flush_i = 0;
        tick();  // pc now 0x44, id_pc 0x40
        rst = 1;
        #1;
        checks++; if (inst_ce_o !== 1'b0) begin failures++; $display("FAIL rst_ce_comb got=%b exp=0", inst_ce_o); end
        tick();
        rst = 0;
        checks++; if (id_valid_o !== 1'b0 || fetch_cnt_o !== 32'd0 || inst_addr_o !== RST_PC || inst_ce_o !== 1'b0) begin
            failures++; $display("FAIL rst_mid valid=%b cnt=%0d addr=%h ce=%b", id_valid_o, fetch_cnt_o, inst_addr_o, inst_ce_o);
        end
        tick();
        checks++; if (inst_ce_o !== 1'b1 || id_valid_o !== 1'b0) begin failures++; $display("FAIL rst_boot ce=%b valid=%b exp 1/0", inst_ce_o, id_valid_o); end
        tick();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== RST_PC) begin failures++; $display("FAIL rst_first valid=%b pc=%h", id_valid_o, id_pc_o); end
    endtask

    task automatic test_random();
        logic exp_ce;
        mem_key = $urandom;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) < 2);
            stall_i  = ($urandom_range(0, 99) < 30);
            flush_i  = ($urandom_range(0, 99) < 12);
            target_i = ($urandom_range(0, 99) < 8) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick();
            rst = 0; stall_i = 0; flush_i = 0;
            #1;
            exp_ce = !m_booting && !m_halted;
            checks++;
            if (inst_ce_o !== exp_ce || inst_addr_o !== m_pc || id_valid_o !== m_valid || id_inst_o !== m_id_inst ||
                misalign_o !== m_mis || fetch_cnt_o !== m_cnt || (m_valid && id_pc_o !== m_id_pc)) begin
                failures++;
                $display("FAIL rand_%0d ce=%b/%b addr=%h/%h valid=%b/%b inst=%h/%h pc=%h/%h mis=%b/%b cnt=%0d/%0d",
                         n, inst_ce_o, exp_ce, inst_addr_o, m_pc, id_valid_o, m_valid, id_inst_o, m_id_inst,
                         id_pc_o, m_id_pc, misalign_o, m_mis, fetch_cnt_o, m_cnt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_wrap();
        test_misalign();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
